// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Perf counters elsewhere are enabled by defining PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } pc_state_e;

    typedef struct packed {
        logic stall;
        logic bubble;
        logic flush;
        logic flush_dx;
        logic idle_wait;
        logic pc_we;
    } hz_ctrl_s;

    // Encoding loaded into FD/DX when a slot is squashed.
    localparam logic [31:0] kNOP = 32'h0000_0000;

    // Counter preload for an N-cycle wait; a zero length behaves as one cycle.
    function automatic logic [15:0] cnt_init(input int unsigned cycles);
        int unsigned eff;
        eff = (cycles == 32'd0) ? 32'd1 : cycles;
        return 16'(eff - 32'd1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the datapath and pipe_ctrl.
// perf_* signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;

    logic       start;
    logic [4:0] rs_fd;
    logic [4:0] rt_fd;
    logic       uses_rt_fd;
    logic       halt_fd;
    logic       mem_read_dx;
    logic [4:0] rd_dx;
    logic       branch_taken_ex;
    logic       dmem_req;
    logic       dmem_ack;

    logic       stall;
    logic       bubble;
    logic       flush;
    logic       flush_dx;
    logic       IDLE_WAIT;
    logic       pc_we;
    logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    // Controller side: consumes pipeline status, drives the controls.
    modport master (
        input  start, rs_fd, rt_fd, uses_rt_fd, halt_fd, mem_read_dx, rd_dx,
               branch_taken_ex, dmem_req, dmem_ack,
`ifdef PIPE_CTRL_PERF_EN
        output perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt,
`endif
        output stall, bubble, flush, flush_dx, IDLE_WAIT, pc_we, state_o
    );

    // Datapath side.
    modport slave (
        output start, rs_fd, rt_fd, uses_rt_fd, halt_fd, mem_read_dx, rd_dx,
               branch_taken_ex, dmem_req, dmem_ack,
`ifdef PIPE_CTRL_PERF_EN
        input  perf_stall_cnt, perf_bubble_cnt, perf_flush_cnt,
`endif
        input  stall, bubble, flush, flush_dx, IDLE_WAIT, pc_we, state_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the DX load writes a register the FD instruction reads.
module hazard_detect (
    input  logic       mem_read_dx,
    input  logic [4:0] rd_dx,
    input  logic [4:0] rs_fd,
    input  logic [4:0] rt_fd,
    input  logic       uses_rt_fd,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (rd_dx == rs_fd);
    assign rt_hit = uses_rt_fd && (rd_dx == rt_fd);

    // r0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = mem_read_dx && (rd_dx != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: warm-up, run, drain and halt FSM.
// Define PIPE_CTRL_PERF_EN to add saturating stall/bubble/flush counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES  = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    pipe_ctrl_if.master  bus
);

    localparam logic [15:0] WARM_LOAD  = cnt_init(WARMUP_CYCLES);
    localparam logic [15:0] DRAIN_LOAD = cnt_init(DRAIN_CYCLES);

    pc_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    hz_ctrl_s    ctrl;
    logic        load_use;
    logic        mem_wait;

    hazard_detect u_hazard_detect (
        .mem_read_dx (bus.mem_read_dx),
        .rd_dx       (bus.rd_dx),
        .rs_fd       (bus.rs_fd),
        .rt_fd       (bus.rt_fd),
        .uses_rt_fd  (bus.uses_rt_fd),
        .load_use    (load_use)
    );

    assign mem_wait = bus.dmem_req && !bus.dmem_ack;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= WARM_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cnt_q == 16'd0) state_d = RUN;
                else                cnt_d   = cnt_q - 16'd1;
            end
            RUN: begin
                // A halt only takes effect when nothing outranks it this cycle.
                if (!mem_wait && !bus.branch_taken_ex && !load_use && bus.halt_fd) begin
                    cnt_d   = DRAIN_LOAD;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!mem_wait) begin
                    if (cnt_q == 16'd0) state_d = HALT;
                    else                cnt_d   = cnt_q - 16'd1;
                end
            end
            HALT: begin
                if (bus.start) begin
                    cnt_d   = WARM_LOAD;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = WARM_LOAD;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            IDLE: ctrl.idle_wait = 1'b1;
            RUN: begin
                if (mem_wait) begin
                    ctrl.stall = 1'b1;
                end else if (bus.branch_taken_ex) begin
                    // Wrong-path FD and DX are squashed; a load-use or halt there is moot.
                    ctrl.flush    = 1'b1;
                    ctrl.flush_dx = 1'b1;
                    ctrl.pc_we    = 1'b1;
                end else if (load_use) begin
                    ctrl.bubble   = 1'b1;
                    ctrl.flush_dx = 1'b1;
                end else if (bus.halt_fd) begin
                    ctrl.idle_wait = 1'b1;
                end else begin
                    ctrl.pc_we = 1'b1;
                end
            end
            DRAIN: begin
                ctrl.idle_wait = 1'b1;
                ctrl.stall     = mem_wait;
            end
            HALT: ctrl.idle_wait = 1'b1;
            default: ctrl.idle_wait = 1'b1;
        endcase
    end

    assign bus.stall     = ctrl.stall;
    assign bus.bubble    = ctrl.bubble;
    assign bus.flush     = ctrl.flush;
    assign bus.flush_dx  = ctrl.flush_dx;
    assign bus.IDLE_WAIT = ctrl.idle_wait;
    assign bus.pc_we     = ctrl.pc_we;
    assign bus.state_o   = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [2:0] perf_evt;
    assign perf_evt = {ctrl.flush, ctrl.bubble, ctrl.stall};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] perf_q, perf_d;

        always_comb begin
            perf_d = perf_q;
            if (perf_evt[gi] && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
        end

        always_ff @(posedge clk) begin
            if (!reset_n) perf_q <= '0;
            else          perf_q <= perf_d;
        end
    end

    assign bus.perf_stall_cnt  = g_perf[0].perf_q;
    assign bus.perf_bubble_cnt = g_perf[1].perf_q;
    assign bus.perf_flush_cnt  = g_perf[2].perf_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: expected control vectors are queued per cycle
// and compared against the DUT outputs mid-cycle. Honours PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.WARMUP_CYCLES(4), .DRAIN_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         exp_stall = 0;
    int         exp_bubble = 0;
    int         exp_flush = 0;

    // Vector layout: {state[1:0], stall, bubble, flush, flush_dx, IDLE_WAIT, pc_we}
    function automatic logic [7:0] ex(input logic [1:0] st, input logic s, input logic b,
                                      input logic f, input logic fd, input logic iw,
                                      input logic pw);
        return {st, s, b, f, fd, iw, pw};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic clear_in();
        bus.start = 0; bus.rs_fd = 0; bus.rt_fd = 0; bus.uses_rt_fd = 0;
        bus.halt_fd = 0; bus.mem_read_dx = 0; bus.rd_dx = 0;
        bus.branch_taken_ex = 0; bus.dmem_req = 0; bus.dmem_ack = 0;
    endtask

    // Called just after a falling edge with inputs already set; consumes one cycle.
    task automatic tick(input string tag, input logic [7:0] want);
        logic [7:0] got;
        logic [7:0] e;
        string      t;
        exp_q.push_back(want);
        tag_q.push_back(tag);
        #1;
        got = {bus.state_o, bus.stall, bus.bubble, bus.flush, bus.flush_dx,
               bus.IDLE_WAIT, bus.pc_we};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {24'd0, got}, {24'd0, e});
        $display("cyc %-14s in{br=%0b lu=%0b/%0d req=%0b ack=%0b halt=%0b start=%0b} out=%h exp=%h",
                 t, bus.branch_taken_ex, bus.mem_read_dx, bus.rd_dx, bus.dmem_req,
                 bus.dmem_ack, bus.halt_fd, bus.start, got, e);
        if (reset_n) begin
            exp_stall  += int'(e[5]);
            exp_bubble += int'(e[4]);
            exp_flush  += int'(e[3]);
        end
        @(negedge clk);
    endtask

    task automatic perf_check(input string tag);
`ifdef PIPE_CTRL_PERF_EN
        check({tag, "_pstall"},  bus.perf_stall_cnt,  32'(exp_stall));
        check({tag, "_pbubble"}, bus.perf_bubble_cnt, 32'(exp_bubble));
        check({tag, "_pflush"},  bus.perf_flush_cnt,  32'(exp_flush));
`else
        $display("perf %s counters not built", tag);
`endif
    endtask

    localparam logic [7:0] V_IDLE  = 8'b00_0000_10;
    localparam logic [7:0] V_RUN   = 8'b01_0000_01;
    localparam logic [7:0] V_DRAIN = 8'b10_0000_10;
    localparam logic [7:0] V_HALT  = 8'b11_0000_10;

    initial begin
        clear_in();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tick("reset", ex(2'd0, 0, 0, 0, 0, 1, 0));
        exp_stall = 0; exp_bubble = 0; exp_flush = 0;
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) tick($sformatf("warm%0d", i), V_IDLE);
        tick("run_first", V_RUN);

        // Load-use via rs, then via rt, plus the r0 and unused-rt exemptions
        bus.mem_read_dx = 1; bus.rd_dx = 5; bus.rs_fd = 5;
        tick("lu_rs", ex(2'd1, 0, 1, 0, 1, 0, 0));
        clear_in();
        tick("lu_after", V_RUN);
        bus.mem_read_dx = 1; bus.rd_dx = 0; bus.rs_fd = 0;
        tick("lu_r0", V_RUN);
        clear_in();
        bus.mem_read_dx = 1; bus.rd_dx = 7; bus.rt_fd = 7; bus.rs_fd = 3; bus.uses_rt_fd = 1;
        tick("lu_rt", ex(2'd1, 0, 1, 0, 1, 0, 0));
        bus.uses_rt_fd = 0;
        tick("lu_rt_unused", V_RUN);

        // Branch outranks load-use and halt
        clear_in();
        bus.branch_taken_ex = 1; bus.mem_read_dx = 1; bus.rd_dx = 5; bus.rs_fd = 5;
        tick("br_lu", ex(2'd1, 0, 0, 1, 1, 0, 1));
        clear_in();
        bus.branch_taken_ex = 1; bus.halt_fd = 1;
        tick("br_halt", ex(2'd1, 0, 0, 1, 1, 0, 1));
        clear_in();
        tick("br_halt_next", V_RUN);

        // Memory wait holds a pending branch until the ack
        bus.dmem_req = 1; bus.branch_taken_ex = 1;
        for (int i = 0; i < 3; i++) tick($sformatf("mstall%0d", i), ex(2'd1, 1, 0, 0, 0, 0, 0));
        bus.dmem_ack = 1;
        tick("mem_ack_br", ex(2'd1, 0, 0, 1, 1, 0, 1));
        clear_in();

        // Halt, clean drain, hold in HALT, restart
        bus.halt_fd = 1;
        tick("halt", ex(2'd1, 0, 0, 0, 0, 1, 0));
        clear_in();
        for (int i = 0; i < 4; i++) tick($sformatf("drain%0d", i), V_DRAIN);
        tick("halted", V_HALT);
        tick("halt_hold", V_HALT);
        bus.start = 1;
        tick("start", V_HALT);
        bus.start = 0;
        for (int i = 0; i < 4; i++) tick($sformatf("rewarm%0d", i), V_IDLE);
        tick("rerun", V_RUN);
        perf_check("mid");

        // Memory wait during drain freezes the countdown
        bus.halt_fd = 1;
        tick("halt2", ex(2'd1, 0, 0, 0, 0, 1, 0));
        clear_in();
        tick("d2_0", V_DRAIN);
        bus.dmem_req = 1;
        tick("d2_stall0", ex(2'd2, 1, 0, 0, 0, 1, 0));
        tick("d2_stall1", ex(2'd2, 1, 0, 0, 0, 1, 0));
        bus.dmem_req = 0;
        for (int i = 1; i < 4; i++) tick($sformatf("d2_%0d", i), V_DRAIN);
        tick("halted2", V_HALT);

        // Reset during a drain-time memory stall
        bus.start = 1;
        tick("start2", V_HALT);
        bus.start = 0;
        for (int i = 0; i < 4; i++) tick($sformatf("warm3_%0d", i), V_IDLE);
        tick("run3", V_RUN);
        bus.halt_fd = 1;
        tick("halt3", ex(2'd1, 0, 0, 0, 0, 1, 0));
        clear_in();
        bus.dmem_req = 1;
        tick("d3_stall", ex(2'd2, 1, 0, 0, 0, 1, 0));
        reset_n = 1'b0;
        tick("d3_rst", ex(2'd2, 1, 0, 0, 0, 1, 0));
        reset_n = 1'b1;
        exp_stall = 0; exp_bubble = 0; exp_flush = 0;
        perf_check("after_rst");
        tick("rst_idle", ex(2'd0, 0, 0, 0, 0, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
